mem_access_unit: RTL and testbench
==================================

MEM_ACCESS_UNIT -- requirements
Module: mem_access_unit

Interface
REQ-001 Parameter DATA_WIDTH, default 32, data and address width.
REQ-002 Port clk  input  1  single clock; all state updates on rising edge.
REQ-003 Port rst  input  1  asynchronous, active-high reset.
REQ-004 Port valid_i  input  1  memory-stage instruction present.
REQ-005 Port resultSRC_i  input  1  load request.
REQ-006 Port memWrite_i  input  1  store request.
REQ-007 Port ALUresult_i  input  DATA_WIDTH  byte address.
REQ-008 Port RD2_i  input  DATA_WIDTH  store data.
REQ-009 Port memType_i  input  2  access size: 00 byte, 01 half, 10 word, 11 reserved.
REQ-010 Port memSign_i  input  1  load extension: 1 sign-extend, 0 zero-extend.
REQ-011 Port stall_o  output  1  freeze upstream pipeline.
REQ-012 Port done_o  output  1  one-cycle access-complete pulse.
REQ-013 Port fault_o  output  1  one-cycle misaligned/reserved-size pulse.
REQ-014 Port readData_o  output  DATA_WIDTH  extended load result, held until next load completes.
REQ-015 Ports mem_req_o, mem_we_o (output, 1), mem_addr_o (output, DATA_WIDTH, bits[1:0]=0), mem_be_o (output, 4), mem_wdata_o (output, DATA_WIDTH): data-memory request.
REQ-016 Ports mem_gnt_i, mem_rvalid_i (input, 1), mem_rdata_i (input, DATA_WIDTH): memory grant, read-valid, read data.

Function
REQ-017 FSM states IDLE, REQ, WAIT, DONE.
REQ-018 Access accepted in IDLE when valid_i and (resultSRC_i or memWrite_i); memWrite_i has priority if both are set.
REQ-019 Misaligned: half with addr[0]=1, word with addr[1:0]!=0, or memType 11; fault_o pulses next cycle, no memory request, FSM stays IDLE, done_o not asserted.
REQ-020 Aligned acceptance latches address, size, sign, write flag, byte enables and write data; FSM enters REQ; later input changes have no effect.
REQ-021 In REQ, mem_req_o=1 with latched fields; on mem_gnt_i: store -> DONE, load -> WAIT; grant on the first REQ cycle is valid.
REQ-022 mem_rvalid_i is ignored until the cycle after grant; in WAIT, mem_rvalid_i captures extracted, extended data into readData_o -> DONE.
REQ-023 DONE: done_o=1 for exactly one cycle, then IDLE; a new access is accepted no earlier than the following IDLE cycle.
REQ-024 stall_o = (IDLE and aligned acceptance, combinational) or state in {REQ, WAIT}; 0 in DONE and on fault.
REQ-025 Byte enables: byte 0001<<addr[1:0]; half 0011 (addr[1]=0) or 1100; word 1111.
REQ-026 Write data: byte replicated to all 4 lanes; half replicated to both halves; word unchanged.
REQ-027 Load extraction selects lane by addr[1:0] (byte) or addr[1] (half), then extends to DATA_WIDTH per memSign.
REQ-028 mem_we_o, mem_addr_o, mem_be_o, mem_wdata_o are 0 whenever mem_req_o=0.

Reset
REQ-029 rst asserted: FSM -> IDLE; stall_o, done_o, fault_o, mem_req_o, readData_o and all latched fields -> 0, immediately regardless of clk.
REQ-030 Reset mid-transaction abandons it; no done_o, and a late mem_rvalid_i after reset is ignored.

Structure
REQ-031 Shared package holds the memType encoding constants and the FSM state enum.
REQ-032 One sub-module, load_extend (combinational lane select plus sign/zero extension), instantiated once.

Verification
REQ-033 Word store addr 0x100, data 0xDEADBEEF, gnt same cycle -> mem_be_o=1111, done_o 2 cycles after acceptance, stall_o high 2 cycles.
REQ-034 Signed byte load addr 0x203, rdata 0x80FF_FF7F... lane3=0x80 -> readData_o=0xFFFFFF80; repeat memSign=0 -> 0x00000080.
REQ-035 Half store addr 0x402, data 0x1234ABCD -> mem_be_o=1100, mem_wdata_o=0xABCDABCD, mem_addr_o=0x400.
REQ-036 Word load addr 0x101 -> fault_o one pulse, mem_req_o never asserted, stall_o 0.
REQ-037 Load with gnt delayed 3 cycles, rvalid 2 cycles later -> stall_o held throughout, mem_req_o held until gnt, single done_o.
REQ-038 rst pulsed while in WAIT, then mem_rvalid_i=1 -> IDLE, readData_o=0, no done_o.

Source files
------------

// File: rtl/mem_access_unit_pkg.sv
// Shared encodings for the memory-access unit: access sizes, FSM states,
// and the alignment / byte-enable helpers used when an access is accepted.
package mem_access_unit_pkg;

  localparam logic [1:0] MEM_BYTE = 2'b00;
  localparam logic [1:0] MEM_HALF = 2'b01;
  localparam logic [1:0] MEM_WORD = 2'b10;
  localparam logic [1:0] MEM_RSVD = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_WAIT = 2'd2,
    ST_DONE = 2'd3
  } state_e;

  // Reserved size counts as a fault, same as a misaligned address.
  function automatic logic misaligned(input logic [1:0] mem_type, input logic [1:0] addr_lo);
    logic bad;
    bad = 1'b0;
    case (mem_type)
      MEM_BYTE: bad = 1'b0;
      MEM_HALF: bad = addr_lo[0];
      MEM_WORD: bad = (addr_lo != 2'b00);
      MEM_RSVD: bad = 1'b1;
      default:  bad = 1'b1;
    endcase
    return bad;
  endfunction

  function automatic logic [3:0] byte_enable(input logic [1:0] mem_type, input logic [1:0] addr_lo);
    logic [3:0] be;
    be = 4'b1111;
    case (mem_type)
      MEM_BYTE: be = 4'b0001 << addr_lo;
      MEM_HALF: be = addr_lo[1] ? 4'b1100 : 4'b0011;
      default:  be = 4'b1111;
    endcase
    return be;
  endfunction

endpackage

// File: rtl/load_extend.sv
// Picks the addressed byte/half lane out of a read word and sign- or
// zero-extends it to the full data width.
module load_extend
  import mem_access_unit_pkg::*;
#(
  parameter int DATA_WIDTH = 32
) (
  input  logic [DATA_WIDTH-1:0] rdata_i,
  input  logic [1:0]            addr_lo_i,
  input  logic [1:0]            mem_type_i,
  input  logic                  sign_i,
  output logic [DATA_WIDTH-1:0] data_o
);

  logic [7:0]  byte_lane;
  logic [15:0] half_lane;

  assign byte_lane = rdata_i[{addr_lo_i, 3'b000} +: 8];
  assign half_lane = rdata_i[{addr_lo_i[1], 4'b0000} +: 16];

  always_comb begin
    data_o = '0;
    case (mem_type_i)
      MEM_BYTE: data_o = sign_i ? DATA_WIDTH'(signed'(byte_lane)) : DATA_WIDTH'(byte_lane);
      MEM_HALF: data_o = sign_i ? DATA_WIDTH'(signed'(half_lane)) : DATA_WIDTH'(half_lane);
      default:  data_o = sign_i ? DATA_WIDTH'(signed'(rdata_i[31:0])) : DATA_WIDTH'(rdata_i[31:0]);
    endcase
  end

endmodule

// File: rtl/mem_access_unit.sv
// Memory-stage access unit: accepts one load/store, issues it to data memory,
// stalls the pipeline while it is outstanding and returns the extended load data.
module mem_access_unit
  import mem_access_unit_pkg::*;
#(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  valid_i,
  input  logic                  resultSRC_i,
  input  logic                  memWrite_i,
  input  logic [DATA_WIDTH-1:0] ALUresult_i,
  input  logic [DATA_WIDTH-1:0] RD2_i,
  input  logic [1:0]            memType_i,
  input  logic                  memSign_i,
  output logic                  stall_o,
  output logic                  done_o,
  output logic                  fault_o,
  output logic [DATA_WIDTH-1:0] readData_o,
  output logic                  mem_req_o,
  output logic                  mem_we_o,
  output logic [DATA_WIDTH-1:0] mem_addr_o,
  output logic [3:0]            mem_be_o,
  output logic [DATA_WIDTH-1:0] mem_wdata_o,
  input  logic                  mem_gnt_i,
  input  logic                  mem_rvalid_i,
  input  logic [DATA_WIDTH-1:0] mem_rdata_i
);

  state_e                state_q;
  logic [DATA_WIDTH-1:0] addr_q;
  logic [DATA_WIDTH-1:0] wdata_q;
  logic [DATA_WIDTH-1:0] rdata_q;
  logic [1:0]            type_q;
  logic                  sign_q;
  logic                  we_q;
  logic [3:0]            be_q;
  logic                  fault_q;

  logic                  req_seen;
  logic                  bad_access;
  logic                  accept;
  logic [DATA_WIDTH-1:0] wdata_d;
  logic [DATA_WIDTH-1:0] load_val;

  assign req_seen   = (state_q == ST_IDLE) && valid_i && (resultSRC_i || memWrite_i);
  assign bad_access = misaligned(memType_i, ALUresult_i[1:0]);
  assign accept     = req_seen && !bad_access;

  // Narrow stores are replicated across lanes; the byte enables pick the live one.
  always_comb begin
    wdata_d = RD2_i;
    case (memType_i)
      MEM_BYTE: wdata_d[31:0] = {4{RD2_i[7:0]}};
      MEM_HALF: wdata_d[31:0] = {2{RD2_i[15:0]}};
      default:  wdata_d[31:0] = RD2_i[31:0];
    endcase
  end

  load_extend #(.DATA_WIDTH(DATA_WIDTH)) u_load_extend (
    .rdata_i    (mem_rdata_i),
    .addr_lo_i  (addr_q[1:0]),
    .mem_type_i (type_q),
    .sign_i     (sign_q),
    .data_o     (load_val)
  );

  // Memory handshake: mem_req_o stays high with stable fields until the cycle
  // mem_gnt_i is seen; a load then takes the first mem_rvalid_i after that cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      type_q  <= 2'b00;
      sign_q  <= 1'b0;
      we_q    <= 1'b0;
      be_q    <= 4'b0000;
      fault_q <= 1'b0;
    end else begin
      fault_q <= req_seen && bad_access;
      case (state_q)
        ST_IDLE: begin
          if (accept) begin
            addr_q  <= ALUresult_i;
            wdata_q <= wdata_d;
            type_q  <= memType_i;
            sign_q  <= memSign_i;
            we_q    <= memWrite_i;
            be_q    <= byte_enable(memType_i, ALUresult_i[1:0]);
            state_q <= ST_REQ;
          end
        end
        ST_REQ: begin
          if (mem_gnt_i) state_q <= we_q ? ST_DONE : ST_WAIT;
        end
        ST_WAIT: begin
          if (mem_rvalid_i) begin
            rdata_q <= load_val;
            state_q <= ST_DONE;
          end
        end
        ST_DONE: state_q <= ST_IDLE;
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign stall_o     = accept || (state_q == ST_REQ) || (state_q == ST_WAIT);
  assign done_o      = (state_q == ST_DONE);
  assign fault_o     = fault_q;
  assign readData_o  = rdata_q;
  assign mem_req_o   = (state_q == ST_REQ);
  assign mem_we_o    = mem_req_o && we_q;
  assign mem_addr_o  = mem_req_o ? {addr_q[DATA_WIDTH-1:2], 2'b00} : '0;
  assign mem_be_o    = mem_req_o ? be_q : 4'b0000;
  assign mem_wdata_o = mem_req_o ? wdata_q : '0;

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit: drives loads/stores and a memory
// responder, and checks outputs against an expected-data queue and constants.
module tb_mem_access_unit;
  import mem_access_unit_pkg::*;

  localparam int W = 32;

  logic         clk, rst;
  logic         valid_i, resultSRC_i, memWrite_i, memSign_i;
  logic [W-1:0] ALUresult_i, RD2_i, mem_rdata_i;
  logic [1:0]   memType_i;
  logic         mem_gnt_i, mem_rvalid_i;
  logic         stall_o, done_o, fault_o, mem_req_o, mem_we_o;
  logic [W-1:0] readData_o, mem_addr_o, mem_wdata_o;
  logic [3:0]   mem_be_o;

  int checks = 0;
  int errors = 0;
  logic [W-1:0] exp_q[$];

  mem_access_unit #(.DATA_WIDTH(W)) dut (
    .clk          (clk),
    .rst          (rst),
    .valid_i      (valid_i),
    .resultSRC_i  (resultSRC_i),
    .memWrite_i   (memWrite_i),
    .ALUresult_i  (ALUresult_i),
    .RD2_i        (RD2_i),
    .memType_i    (memType_i),
    .memSign_i    (memSign_i),
    .stall_o      (stall_o),
    .done_o       (done_o),
    .fault_o      (fault_o),
    .readData_o   (readData_o),
    .mem_req_o    (mem_req_o),
    .mem_we_o     (mem_we_o),
    .mem_addr_o   (mem_addr_o),
    .mem_be_o     (mem_be_o),
    .mem_wdata_o  (mem_wdata_o),
    .mem_gnt_i    (mem_gnt_i),
    .mem_rvalid_i (mem_rvalid_i),
    .mem_rdata_i  (mem_rdata_i)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    valid_i      = 1'b0;
    resultSRC_i  = 1'b0;
    memWrite_i   = 1'b0;
    memSign_i    = 1'b0;
    memType_i    = MEM_WORD;
    ALUresult_i  = $urandom;
    RD2_i        = $urandom;
    mem_gnt_i    = 1'b0;
    mem_rvalid_i = 1'b0;
    mem_rdata_i  = $urandom;
  endtask

  // Reference load result, computed by shifting and masking.
  function automatic logic [W-1:0] model_load(input logic [W-1:0] rd, input logic [W-1:0] addr,
                                              input logic [1:0] mt, input logic sgn);
    logic [W-1:0] r;
    if (mt == MEM_BYTE) begin
      r = (rd >> (8 * int'(addr[1:0]))) & 32'h0000_00FF;
      if (sgn && r[7]) r = r | 32'hFFFF_FF00;
    end else if (mt == MEM_HALF) begin
      r = (rd >> (16 * int'(addr[1]))) & 32'h0000_FFFF;
      if (sgn && r[15]) r = r | 32'hFFFF_0000;
    end else begin
      r = rd;
    end
    return r;
  endfunction

  // Driver: one full access with a memory responder (gnt after gnt_dly REQ
  // cycles, rvalid rv_dly cycles after the grant cycle).
  task automatic run_access(input string tag, input logic st, input logic [W-1:0] addr,
                            input logic [W-1:0] data, input logic [1:0] mt, input logic sgn,
                            input logic [W-1:0] rd, input int gnt_dly, input int rv_dly,
                            input logic [3:0] exp_be, input logic [W-1:0] exp_wdata);
    if (!st) exp_q.push_back(model_load(rd, addr, mt, sgn));
    valid_i     = 1'b1;
    memWrite_i  = st;
    resultSRC_i = 1'b1;
    ALUresult_i = addr;
    RD2_i       = data;
    memType_i   = mt;
    memSign_i   = sgn;
    #1;
    chk({tag, " accept_stall"}, stall_o, 1);
    chk({tag, " idle_no_req"}, mem_req_o, 0);
    tick();
    valid_i     = 1'b0;
    memWrite_i  = 1'b0;
    resultSRC_i = 1'b0;
    ALUresult_i = $urandom;
    RD2_i       = $urandom;
    memType_i   = 2'($urandom_range(0, 3));
    memSign_i   = ~sgn;
    for (int c = 0; c <= gnt_dly; c++) begin
      mem_gnt_i    = (c == gnt_dly);
      mem_rvalid_i = (c == gnt_dly) && !st;
      mem_rdata_i  = ~rd;
      #1;
      chk({tag, " req"}, mem_req_o, 1);
      chk({tag, " req_stall"}, stall_o, 1);
      chk({tag, " addr"}, mem_addr_o, {addr[W-1:2], 2'b00});
      chk({tag, " be"}, mem_be_o, exp_be);
      chk({tag, " we"}, mem_we_o, st);
      if (st) chk({tag, " wdata"}, mem_wdata_o, exp_wdata);
      tick();
    end
    mem_gnt_i    = 1'b0;
    mem_rvalid_i = 1'b0;
    if (!st) begin
      for (int c = 1; c <= rv_dly; c++) begin
        mem_rvalid_i = (c == rv_dly);
        mem_rdata_i  = (c == rv_dly) ? rd : ~rd;
        #1;
        chk({tag, " wait_stall"}, stall_o, 1);
        chk({tag, " wait_no_req"}, mem_req_o, 0);
        chk({tag, " wait_addr_zero"}, mem_addr_o, 0);
        chk({tag, " wait_no_done"}, done_o, 0);
        tick();
      end
      mem_rvalid_i = 1'b0;
      mem_rdata_i  = $urandom;
    end
    // DONE cycle: a fresh aligned request here must not be taken.
    valid_i     = 1'b1;
    memWrite_i  = 1'b1;
    ALUresult_i = 32'h0000_0010;
    memType_i   = MEM_WORD;
    #1;
    chk({tag, " done"}, done_o, 1);
    chk({tag, " done_stall"}, stall_o, 0);
    chk({tag, " done_no_req"}, mem_req_o, 0);
    if (!st) begin
      if (exp_q.size() > 0) chk({tag, " rdata"}, readData_o, exp_q.pop_front());
      else chk({tag, " scoreboard_underflow"}, 1, 0);
    end
    tick();
    idle_inputs();
    #1;
    chk({tag, " done_pulse_end"}, done_o, 0);
    chk({tag, " no_accept_in_done"}, mem_req_o, 0);
  endtask

  task automatic run_fault(input string tag, input logic st, input logic [W-1:0] addr,
                           input logic [1:0] mt);
    valid_i     = 1'b1;
    memWrite_i  = st;
    resultSRC_i = !st;
    ALUresult_i = addr;
    memType_i   = mt;
    RD2_i       = $urandom;
    #1;
    chk({tag, " fault_stall"}, stall_o, 0);
    chk({tag, " fault_no_pulse_yet"}, fault_o, 0);
    tick();
    idle_inputs();
    #1;
    chk({tag, " fault_pulse"}, fault_o, 1);
    chk({tag, " fault_no_req"}, mem_req_o, 0);
    chk({tag, " fault_no_stall"}, stall_o, 0);
    chk({tag, " fault_no_done"}, done_o, 0);
    tick();
    #1;
    chk({tag, " fault_pulse_end"}, fault_o, 0);
    chk({tag, " fault_still_idle"}, mem_req_o, 0);
  endtask

  initial begin
    logic [1:0]   mt;
    logic [W-1:0] a;
    logic [3:0]   be;

    rst = 1'b1;
    idle_inputs();
    tick();
    tick();
    chk("rst stall", stall_o, 0);
    chk("rst done", done_o, 0);
    chk("rst fault", fault_o, 0);
    chk("rst req", mem_req_o, 0);
    chk("rst rdata", readData_o, 0);
    chk("rst addr", mem_addr_o, 0);
    chk("rst be", mem_be_o, 0);
    rst = 1'b0;
    tick();

    run_access("st_word", 1'b1, 32'h0000_0100, 32'hDEAD_BEEF, MEM_WORD, 1'b0, '0, 0, 0,
               4'b1111, 32'hDEAD_BEEF);
    run_access("ld_byte_s", 1'b0, 32'h0000_0203, '0, MEM_BYTE, 1'b1, 32'h80FF_FF7F, 0, 1,
               4'b1000, '0);
    chk("ld_byte_s value", readData_o, 32'hFFFF_FF80);
    run_access("ld_byte_u", 1'b0, 32'h0000_0203, '0, MEM_BYTE, 1'b0, 32'h80FF_FF7F, 0, 1,
               4'b1000, '0);
    chk("ld_byte_u value", readData_o, 32'h0000_0080);
    run_access("st_half", 1'b1, 32'h0000_0402, 32'h1234_ABCD, MEM_HALF, 1'b0, '0, 0, 0,
               4'b1100, 32'hABCD_ABCD);
    run_access("st_byte", 1'b1, 32'h0000_0201, 32'h1122_3355, MEM_BYTE, 1'b0, '0, 1, 0,
               4'b0010, 32'h5555_5555);

    run_fault("ld_word_mis", 1'b0, 32'h0000_0101, MEM_WORD);
    run_fault("st_half_mis", 1'b1, 32'h0000_0403, MEM_HALF);
    run_fault("rsvd_size", 1'b0, 32'h0000_0400, MEM_RSVD);
    chk("fault keeps rdata", readData_o, 32'h0000_0080);

    run_access("ld_word_slow", 1'b0, 32'h0000_0500, '0, MEM_WORD, 1'b1, 32'hCAFE_F00D, 3, 2,
               4'b1111, '0);
    chk("ld_word_slow value", readData_o, 32'hCAFE_F00D);
    run_access("ld_half_s", 1'b0, 32'h0000_0306, '0, MEM_HALF, 1'b1, 32'h8001_7FFF, 1, 1,
               4'b1100, '0);
    chk("ld_half_s value", readData_o, 32'hFFFF_8001);
    run_access("ld_half_u", 1'b0, 32'h0000_0304, '0, MEM_HALF, 1'b0, 32'h8001_8FFF, 0, 2,
               4'b0011, '0);
    chk("ld_half_u value", readData_o, 32'h0000_8FFF);

    for (int i = 0; i < 6; i++) begin
      mt = 2'($urandom_range(0, 2));
      a  = $urandom & 32'h0000_0FFF;
      if (mt == MEM_HALF) a[0] = 1'b0;
      else if (mt == MEM_WORD) a[1:0] = 2'b00;
      be = (mt == MEM_BYTE) ? (4'b0001 << a[1:0]) :
           (mt == MEM_HALF) ? (a[1] ? 4'b1100 : 4'b0011) : 4'b1111;
      run_access($sformatf("ld_rnd%0d", i), 1'b0, a, $urandom, mt, 1'($urandom_range(0, 1)),
                 $urandom, int'($urandom_range(0, 2)), int'($urandom_range(1, 3)), be, '0);
    end

    // Reset while a load waits for read data.
    valid_i     = 1'b1;
    resultSRC_i = 1'b1;
    ALUresult_i = 32'h0000_0600;
    memType_i   = MEM_WORD;
    memSign_i   = 1'b0;
    tick();
    idle_inputs();
    mem_gnt_i = 1'b1;
    tick();
    mem_gnt_i = 1'b0;
    #1;
    chk("rst_wait stall_before", stall_o, 1);
    #2 rst = 1'b1;
    #1;
    chk("rst_wait async_stall", stall_o, 0);
    chk("rst_wait async_rdata", readData_o, 0);
    chk("rst_wait async_req", mem_req_o, 0);
    tick();
    rst          = 1'b0;
    mem_rvalid_i = 1'b1;
    mem_rdata_i  = 32'h1234_5678;
    #1;
    chk("rst_wait late_rv_stall", stall_o, 0);
    tick();
    mem_rvalid_i = 1'b0;
    #1;
    chk("rst_wait no_done", done_o, 0);
    chk("rst_wait rdata_zero", readData_o, 0);
    chk("rst_wait idle_req", mem_req_o, 0);
    tick();
    #1;
    chk("rst_wait still_no_done", done_o, 0);

    chk("scoreboard empty", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
